count_display: RTL and testbench
================================

Name: count_display

Overview:
- Consumer end of the button/switch counter interface. Takes two 7-bit unsigned count values and shows each one as three decimal digits on six seven-segment displays (HEX2..HEX0 for value_a, HEX5..HEX3 for value_b).
- Binary-to-BCD conversion is sequential (double-dabble, one bit per clock).
- A new conversion starts whenever either input differs from the last converted snapshot.
- Sits between the counter blocks and the board display pins.

Parameters:
- BLANK_LZ, 1, 1 = blank leading-zero digits (units digit is never blanked); 0 = always show three digits.
- ACTIVE_LOW, 1, 1 = segment outputs are active-low (board default); 0 = invert all segment outputs.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- value_a  input  7  unsigned count, 0..127, shown on HEX2..HEX0.
- value_b  input  7  unsigned count, 0..127, shown on HEX5..HEX3.
- HEX0..HEX5  output  7 each  segment patterns, bit0 = a ... bit6 = g; HEX0/HEX3 are units digits.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the HEX outputs have just been updated.

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE; busy = 0; done = 0.
  - All HEX outputs = blank (7'h7F when ACTIVE_LOW = 1).
  - Snapshot registers = 0; force flag = 1.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - Trigger on any rising edge where force = 1, or value_a != snap_a, or value_b != snap_b.
  - On trigger, at that edge (E0): capture both inputs into shadow registers and snapshot registers, clear force, clear both BCD accumulators, bit counter = 0, state -> SHIFT, busy -> 1.
- SHIFT, edges E1..E7:
  - Each edge, per engine: every BCD digit >= 5 gets +3, then shift {bcd, shadow} left by 1.
  - Both engines run in lockstep.
  - At E7 (bit counter = 6) state -> COMMIT.
- COMMIT, edge E8:
  - Decode digits into the HEX registers; done -> 1 for exactly one cycle; busy -> 0; state -> IDLE.
- Latency: HEX outputs change exactly 8 rising edges after the edge that sampled the change. Earliest retrigger is E9.
- Input changes during SHIFT/COMMIT are not sampled. The IDLE compare against the snapshot catches the latest value at E9 or later. Intermediate values may never be displayed; only the final settled value is guaranteed.
- Simultaneous change of value_a and value_b produces one conversion covering both.
- Wrap-around (127 -> 0, 0 -> 127) is just a value change; no special handling.
- Digit encoding (active-low):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
  - blank = 7'h7F
  - When ACTIVE_LOW = 0, outputs are the bitwise inverse.
- Blanking with BLANK_LZ = 1:
  - Hundreds digit is blank if it is 0.
  - Tens digit is blank if hundreds = 0 and tens = 0.
- BCD digit values never exceed 9. The hundreds digit is at most 1.
- Reset asserted mid-SHIFT/COMMIT aborts immediately to reset values. After release, force = 1 triggers a conversion at the first edge.
- HEX outputs are registered and hold their value between commits. They are not disturbed during SHIFT.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/SHIFT/COMMIT).
  - Seven-segment digit constants 0-9 and SEG_BLANK.
  - Width constants VAL_W = 7, DIGITS = 3, BCD_W = 12.
- Sub-module bin2bcd_serial: one 7-bit serial double-dabble engine.
  - Ports: clk, rst, load, shift_en, bin_in[6:0], bcd_out[11:0].
  - Instantiated twice.
- Segment decode and blanking stay in count_display.

Test Plan:
- Reset, then release with inputs 0/0 -> all HEX = 7'h7F during reset; on the 9th edge after release done pulses; HEX0 = HEX3 = 7'h40, others 7'h7F.
- value_a = 127 applied while IDLE -> busy for 8 cycles; then HEX2 = 7'h79, HEX1 = 7'h24, HEX0 = 7'h78; done is high exactly 1 cycle; HEX5..HEX3 unchanged.
- value_b steps 0 -> 127 (wrap) and simultaneously value_a 10 -> 9 -> exactly one done pulse; HEX5/4/3 = 7'h79/7'h24/7'h78; HEX2 = 7'h7F, HEX1 = 7'h7F, HEX0 = 7'h10.
- value_a 5 -> 63 at E3 of an in-progress conversion -> the first commit shows 5 (HEX0 = 7'h12); a second conversion starts at E9; final HEX1 = 7'h02, HEX0 = 7'h30.
- rst pulsed during SHIFT with value_a = 88 -> outputs blank immediately, busy = 0; after release the first done shows HEX1 = HEX0 = 7'h00.
- BLANK_LZ = 0, value_a = 5 -> HEX2 = 7'h40, HEX1 = 7'h40, HEX0 = 7'h12; ACTIVE_LOW = 0 gives the bitwise-inverted patterns.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display: FSM encoding, widths and
// the active-low seven-segment digit patterns (bit0 = a ... bit6 = g).
package count_display_pkg;

  localparam int unsigned VAL_W  = 7;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BCD_W  = 12;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low pattern for one BCD digit; non-decimal codes show blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/count_display_bin2bcd_serial.sv
// Serial double-dabble engine: load captures the binary value and clears the
// BCD accumulator; each shift_en cycle adjusts digits >= 5 by +3 and then
// shifts {bcd, shadow} left by one. Seven shifts give the final BCD value.
module bin2bcd_serial import count_display_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [VAL_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out
);

  logic [VAL_W-1:0] shadow;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load or shift the combined BCD/binary register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      bcd    <= '0;
    end else if (load) begin
      shadow <= bin_in;
      bcd    <= '0;
    end else if (shift_en) begin
      {bcd, shadow} <= {bcd_adj, shadow} << 1;
    end
  end

  assign bcd_out = bcd;

endmodule

// File: rtl/count_display.sv
// Shows two 7-bit counts as three decimal digits each on six seven-segment
// displays. A conversion runs whenever an input differs from the last snapshot;
// HEX outputs are registered and only change on the commit cycle.
module count_display import count_display_pkg::*; #(
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value_a,
  input  logic [VAL_W-1:0] value_b,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic             busy,
  output logic             done
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e           state;
  logic [VAL_W-1:0] snap_a;
  logic [VAL_W-1:0] snap_b;
  logic             force_flag;
  logic [2:0]       bit_cnt;
  logic [BCD_W-1:0] bcd_a;
  logic [BCD_W-1:0] bcd_b;
  logic [20:0]      disp_a;
  logic [20:0]      disp_b;
  logic             trigger;
  logic             load;
  logic             shift_en;

  assign trigger  = force_flag || (value_a != snap_a) || (value_b != snap_b);
  assign load     = (state == StIdle) && trigger;
  assign shift_en = (state == StShift);

  bin2bcd_serial u_conv_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .bin_in   (value_a),
    .bcd_out  (bcd_a)
  );

  bin2bcd_serial u_conv_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .bin_in   (value_b),
    .bcd_out  (bcd_b)
  );

  // Three digit patterns {hundreds, tens, units} with leading-zero blanking
  // and output polarity applied.
  function automatic logic [20:0] render(input logic [BCD_W-1:0] bcd);
    logic [3:0]  h;
    logic [3:0]  t;
    logic [6:0]  ph;
    logic [6:0]  pt;
    logic [6:0]  pu;
    logic [20:0] r;
    h  = bcd[11:8];
    t  = bcd[7:4];
    ph = (BLANK_LZ && h == 4'd0) ? SEG_BLANK : seg_digit(h);
    pt = (BLANK_LZ && h == 4'd0 && t == 4'd0) ? SEG_BLANK : seg_digit(t);
    pu = seg_digit(bcd[3:0]);
    r  = {ph, pt, pu};
    return ACTIVE_LOW ? r : ~r;
  endfunction

  // Decode both BCD accumulators; only sampled into HEX during commit.
  always_comb begin
    disp_a = render(bcd_a);
    disp_b = render(bcd_b);
  end

  // Control FSM with registered busy/done and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      snap_a     <= '0;
      snap_b     <= '0;
      force_flag <= 1'b1;
      bit_cnt    <= '0;
      HEX0       <= SEG_OFF;
      HEX1       <= SEG_OFF;
      HEX2       <= SEG_OFF;
      HEX3       <= SEG_OFF;
      HEX4       <= SEG_OFF;
      HEX5       <= SEG_OFF;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (trigger) begin
            snap_a     <= value_a;
            snap_b     <= value_b;
            force_flag <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= StShift;
          end
        end
        StShift: begin
          // Seven shifts: bit_cnt 0..6, leaving on the one where it reads 6.
          if (bit_cnt == 3'd6) begin
            state <= StCommit;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        StCommit: begin
          {HEX2, HEX1, HEX0} <= disp_a;
          {HEX5, HEX4, HEX3} <= disp_b;
          done               <= 1'b1;
          busy               <= 1'b0;
          state              <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: a default instance and an instance with
// BLANK_LZ = 0 / ACTIVE_LOW = 0 share the same inputs. Expected display
// images are queued when values are driven and popped on each done pulse.
module tb_count_display;

  typedef struct packed {
    logic [41:0] h1;
    logic [41:0] h2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] value_a;
  logic [6:0] value_b;
  logic [6:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
  logic [6:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
  logic       a_busy, a_done, b_busy, b_done;
  logic [41:0] hex1, hex2;

  exp_t sb_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_pass = 0;

  count_display u_dut (
    .clk     (clk),
    .rst     (rst),
    .value_a (value_a),
    .value_b (value_b),
    .HEX0    (a_hex0),
    .HEX1    (a_hex1),
    .HEX2    (a_hex2),
    .HEX3    (a_hex3),
    .HEX4    (a_hex4),
    .HEX5    (a_hex5),
    .busy    (a_busy),
    .done    (a_done)
  );

  count_display #(
    .BLANK_LZ   (1'b0),
    .ACTIVE_LOW (1'b0)
  ) u_dut_inv (
    .clk     (clk),
    .rst     (rst),
    .value_a (value_a),
    .value_b (value_b),
    .HEX0    (b_hex0),
    .HEX1    (b_hex1),
    .HEX2    (b_hex2),
    .HEX3    (b_hex3),
    .HEX4    (b_hex4),
    .HEX5    (b_hex5),
    .busy    (b_busy),
    .done    (b_done)
  );

  assign hex1 = {a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0};
  assign hex2 = {b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] enc3(input int v, input bit blz, input bit al);
    int h, t, u;
    logic [20:0] r;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    r[20:14] = (blz && h == 0) ? 7'h7F : pat(h);
    r[13:7]  = (blz && h == 0 && t == 0) ? 7'h7F : pat(t);
    r[6:0]   = pat(u);
    return al ? r : ~r;
  endfunction

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.h1 = {enc3(b, 1'b1, 1'b1), enc3(a, 1'b1, 1'b1)};
    e.h2 = {enc3(b, 1'b0, 1'b0), enc3(a, 1'b0, 1'b0)};
    return e;
  endfunction

  task automatic drive(input int a, input int b);
    value_a = 7'(a);
    value_b = 7'(b);
    sb_q.push_back(model(a, b));
  endtask

  // Wait (bounded) for done; displays must hold until then. Returns negedges
  // elapsed and how many of them saw busy.
  task automatic wait_done(input string tag, output int cyc, output int busy_cyc);
    bit   seen;
    exp_t e;
    seen     = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_busy) busy_cyc++;
      if (a_done) begin
        seen = 1'b1;
        check({tag, "_inv_done"}, 64'(b_done), 64'd1);
        if (sb_q.size() == 0) begin
          check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_hex"}, 64'(hex1), 64'(e.h1));
          check({tag, "_hex_inv"}, 64'(hex2), 64'(e.h2));
          last = e;
        end
      end else if (hex1 !== last.h1 || hex2 !== last.h2) begin
        check({tag, "_hold"}, {hex1, 22'd0}, {last.h1, 22'd0});
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      check({tag, "_done_1cyc"}, 64'(a_done), 64'd0);
    end
  endtask

  initial begin
    int cyc, bcyc, n_done;
    rst     = 1'b1;
    value_a = '0;
    value_b = '0;
    last.h1 = {6{7'h7F}};
    last.h2 = '0;
    repeat (2) @(negedge clk);
    check("rst_hex", 64'(hex1), {22'd0, {6{7'h7F}}});
    check("rst_hex_inv", 64'(hex2), 64'd0);
    check("rst_busy_done", {62'd0, a_busy, a_done}, 64'd0);

    // Release: force flag converts 0/0 on the first edge.
    rst = 1'b0;
    sb_q.push_back(model(0, 0));
    wait_done("init", cyc, bcyc);
    check("init_latency", 64'(cyc), 64'd9);

    // value_a = 127 from idle.
    drive(127, 0);
    wait_done("a127", cyc, bcyc);
    check("a127_latency", 64'(cyc), 64'd9);
    check("a127_busy", 64'(bcyc), 64'd8);

    // a = 10, then a and b change together: one conversion.
    drive(10, 0);
    wait_done("a10", cyc, bcyc);
    drive(9, 127);
    wait_done("both", cyc, bcyc);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_done) n_done++;
    end
    check("both_single", 64'(n_done), 64'd0);

    // Input changes mid-conversion: 5 is shown first, then 63.
    drive(5, 127);
    repeat (3) @(negedge clk);
    drive(63, 127);
    wait_done("mid5", cyc, bcyc);
    check("mid5_latency", 64'(cyc), 64'd6);
    wait_done("mid63", cyc, bcyc);
    check("mid63_latency", 64'(cyc), 64'd8);

    // Reset during SHIFT aborts to blank, then reconverts 88.
    drive(88, 127);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_hex", 64'(hex1), {22'd0, {6{7'h7F}}});
    check("abort_hex_inv", 64'(hex2), 64'd0);
    check("abort_busy", 64'(a_busy), 64'd0);
    sb_q.delete();
    last.h1 = {6{7'h7F}};
    last.h2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(model(88, 127));
    wait_done("post_rst", cyc, bcyc);
    check("post_rst_latency", 64'(cyc), 64'd9);

    // b wraps 127 -> 0, a = 5: checks unblanked/inverted instance too.
    drive(5, 0);
    wait_done("a5", cyc, bcyc);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
